// File: rtl/inst_pkg.sv
// Shared types and constants for the RV32I instruction encoder: formats, error
// codes, canonical opcodes and the NOP substituted for unencodable words.
package inst_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    EC_NONE  = 2'd0,
    EC_RANGE = 2'd1,
    EC_ALIGN = 2'd2,
    EC_FMT   = 2'd3
  } ecode_e;

  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when imm is representable as a 'bits'-wide two's-complement value.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned bits);
    logic signed [31:0] sh;
    sh = $signed(imm) >>> (bits - 1);
    return (sh == '0) || (sh == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Input-field and output-word handshake bundle of the instruction encoder.
interface inst_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [1:0]        out_ecode;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, out_ecode
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, out_ecode
  );
endinterface

// File: rtl/inst_pack.sv
// Combinational RV32I field packer with immediate legality check; unencodable
// requests collapse to NOP with an error code.
module inst_pack
  import inst_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        err_o,
  output ecode_e      ecode_o
);

  logic [31:0] raw;

  // Alignment is tested before range so an odd offset reports as misaligned.
  always_comb begin
    raw     = '0;
    ecode_o = EC_NONE;
    case (fmt_e'(fmt_i))
      FMT_R: raw = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        if (!fits_signed(imm_i, 12)) ecode_o = EC_RANGE;
      end
      FMT_S: begin
        raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        if (!fits_signed(imm_i, 12)) ecode_o = EC_RANGE;
      end
      FMT_B: begin
        raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
        if (imm_i[0])                     ecode_o = EC_ALIGN;
        else if (!fits_signed(imm_i, 13)) ecode_o = EC_RANGE;
      end
      FMT_U: begin
        raw = {imm_i[31:12], rd_i, opcode_i};
        if (imm_i[11:0] != 12'd0) ecode_o = EC_FMT;
      end
      FMT_J: begin
        raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        if (imm_i[0])                     ecode_o = EC_ALIGN;
        else if (!fits_signed(imm_i, 21)) ecode_o = EC_RANGE;
      end
      default: ecode_o = EC_FMT;
    endcase
  end

  assign err_o  = (ecode_o != EC_NONE);
  assign inst_o = err_o ? NOP : raw;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs fields into RV32I words, tags each with a running
// byte address and buffers them in a 2-entry FIFO toward the memory loader.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic           clk,
  input logic           reset,
  inst_encoder_if.slave bus
);

  logic [31:0] pk_inst;
  logic        pk_err;
  ecode_e      pk_ecode;

  inst_pack u_pack (
    .fmt_i    (bus.in_fmt),
    .opcode_i (bus.in_opcode),
    .rd_i     (bus.in_rd),
    .rs1_i    (bus.in_rs1),
    .rs2_i    (bus.in_rs2),
    .funct3_i (bus.in_funct3),
    .funct7_i (bus.in_funct7),
    .imm_i    (bus.in_imm),
    .inst_o   (pk_inst),
    .err_o    (pk_err),
    .ecode_o  (pk_ecode)
  );

  logic [31:0]       inst_mem_q  [2];
  logic [ADDR_W-1:0] addr_mem_q  [2];
  logic              err_mem_q   [2];
  logic [1:0]        ecode_mem_q [2];

  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              in_ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic              push, pop, out_valid;

  assign out_valid = (cnt_q != 2'd0);
  assign push      = bus.in_valid & in_ready_q;
  assign pop       = out_valid & bus.out_ready;
  assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};

  // in_ready is computed from next occupancy and registered, so a pop while
  // full only reopens the input on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
      addr_q     <= BASE_ADDR;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d < 2'd2);
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
        addr_q   <= addr_q + ADDR_W'(4);
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q]  <= pk_inst;
      addr_mem_q[wr_ptr_q]  <= addr_q;
      err_mem_q[wr_ptr_q]   <= pk_err;
      ecode_mem_q[wr_ptr_q] <= pk_ecode;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_inst  = out_valid ? inst_mem_q[rd_ptr_q]  : 32'd0;
  assign bus.out_addr  = out_valid ? addr_mem_q[rd_ptr_q]  : '0;
  assign bus.out_err   = out_valid ? err_mem_q[rd_ptr_q]   : 1'b0;
  assign bus.out_ecode = out_valid ? ecode_mem_q[rd_ptr_q] : 2'd0;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed encodings, error codes,
// backpressure, address wrap and mid-stream reset.
module tb_inst_encoder;
  import inst_pkg::*;

  localparam logic [31:0] BASE0 = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  inst_encoder_if #(.ADDR_W(32)) bus0 ();
  inst_encoder_if #(.ADDR_W(4))  bus1 ();

  inst_encoder #(.ADDR_W(32), .BASE_ADDR(BASE0)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  inst_encoder #(.ADDR_W(4),  .BASE_ADDR(4'd12)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
    logic [1:0]  ecode;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_addr;

  // Reference immediate generator (decode direction).
  function automatic logic [31:0] imm_gen(input logic [2:0] fmt, input logic [31:0] i);
    case (fmt)
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {i[31:12], 12'd0};
      3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] e_inst, input logic [1:0] e_code);
    exp_t e;
    int   t;
    @(negedge clk);
    bus0.in_fmt    = fmt;
    bus0.in_opcode = op;
    bus0.in_rd     = rd;
    bus0.in_rs1    = rs1;
    bus0.in_rs2    = rs2;
    bus0.in_funct3 = f3;
    bus0.in_funct7 = f7;
    bus0.in_imm    = imm;
    bus0.in_valid  = 1'b1;
    t = 0;
    while (!bus0.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus0.in_ready) begin
      check("accept_timeout", bus0.in_ready, 1);
      bus0.in_valid = 1'b0;
      return;
    end
    e.inst  = e_inst;
    e.addr  = exp_addr;
    e.err   = (e_code != 2'd0);
    e.ecode = e_code;
    e.fmt   = fmt;
    e.imm   = imm;
    sb.push_back(e);
    exp_addr = exp_addr + 32'd4;
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check(tag, sb.size(), 0);
  endtask

  task automatic push1(input logic [31:0] imm);
    @(negedge clk);
    bus1.in_fmt    = 3'd1;
    bus1.in_opcode = 7'h13;
    bus1.in_rd     = 5'd1;
    bus1.in_rs1    = 5'd0;
    bus1.in_rs2    = 5'd0;
    bus1.in_funct3 = 3'd0;
    bus1.in_funct7 = 7'd0;
    bus1.in_imm    = imm;
    bus1.in_valid  = 1'b1;
    check("w_in_ready", bus1.in_ready, 1);
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
  endtask

  // Output monitor for dut0: scoreboard pops and stall-stability checks.
  initial begin
    exp_t        e;
    logic        held;
    logic [31:0] h_inst, h_addr;
    held = 1'b0;
    h_inst = '0;
    h_addr = '0;
    forever begin
      @(negedge clk);
      if (rst0) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", bus0.out_valid, 1);
          check("stall_inst", bus0.out_inst, h_inst);
          check("stall_addr", bus0.out_addr, h_addr);
        end
        held   = bus0.out_valid && !bus0.out_ready;
        h_inst = bus0.out_inst;
        h_addr = bus0.out_addr;
        if (bus0.out_valid && bus0.out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", bus0.out_valid, 0);
          end else begin
            e = sb.pop_front();
            check("inst", bus0.out_inst, e.inst);
            check("addr", bus0.out_addr, e.addr);
            check("err", bus0.out_err, e.err);
            check("ecode", bus0.out_ecode, e.ecode);
            if (!e.err && e.fmt != 3'd0)
              check("roundtrip", imm_gen(e.fmt, bus0.out_inst), e.imm);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d queued", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    exp_addr = BASE0;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    bus0.in_fmt = '0; bus0.in_opcode = '0; bus0.in_rd = '0; bus0.in_rs1 = '0;
    bus0.in_rs2 = '0; bus0.in_funct3 = '0; bus0.in_funct7 = '0; bus0.in_imm = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.in_fmt = '0; bus1.in_opcode = '0; bus1.in_rd = '0; bus1.in_rs1 = '0;
    bus1.in_rs2 = '0; bus1.in_funct3 = '0; bus1.in_funct7 = '0; bus1.in_imm = '0;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0; rst1 = 1'b0;

    @(negedge clk);
    check("rst_valid", bus0.out_valid, 0);
    check("rst_inst", bus0.out_inst, 0);
    check("rst_err", bus0.out_err, 0);
    check("rst_ecode", bus0.out_ecode, 0);
    check("rst_in_ready", bus0.in_ready, 1);
    check("rst_valid1", bus1.out_valid, 0);

    // Legal encodings
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
    @(negedge clk);
    check("lat1_valid", bus0.out_valid, 1);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 2'd0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'd0);
    send(3'd5, 7'h6F, 5'd1, 5'd9, 5'd9, 3'd7, 7'h7F, 32'h0000_0800, 32'h0010_00EF, 2'd0);
    send(3'd4, 7'h37, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'h0020_81B3, 2'd0);
    send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0013, 2'd0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0FFE, 32'h7E00_0FE3, 2'd0);
    send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 32'h8000_006F, 2'd0);
    // Unencodable requests
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h13, 2'd1);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_F7FF, 32'h13, 2'd1);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,          32'h13, 2'd2);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,       32'h13, 2'd1);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_2001, 32'h13, 2'd2);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h13, 2'd1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,          32'h13, 2'd2);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h13, 2'd3);
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,          32'h13, 2'd3);
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,          32'h13, 2'd3);
    drain("drain_directed");

    // Backpressure: two accepts fill the FIFO, the third waits
    @(posedge clk);
    #1 bus0.out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10, 32'h00A0_0113, 2'd0);
    send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd11, 32'h00B0_0193, 2'd0);
    @(negedge clk);
    check("full_in_ready", bus0.in_ready, 0);
    check("full_valid", bus0.out_valid, 1);
    fork
      send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd12, 32'h00C0_0213, 2'd0);
    join_none
    repeat (3) @(negedge clk);
    check("held_in_ready", bus0.in_ready, 0);
    check("held_head_inst", bus0.out_inst, 32'h00A0_0113);
    @(posedge clk);
    #1 bus0.out_ready = 1'b1;
    drain("drain_backpressure");

    // Address wrap and mid-stream reset on the 4-bit-address instance
    push1(32'd1);
    push1(32'd2);
    @(negedge clk);
    check("wrap_valid", bus1.out_valid, 1);
    check("wrap_addr0", bus1.out_addr, 12);
    check("wrap_inst0", bus1.out_inst, 32'h0010_0093);
    @(posedge clk);
    #1 bus1.out_ready = 1'b1;
    @(posedge clk);
    #1 bus1.out_ready = 1'b0;
    @(negedge clk);
    check("wrap_addr1", bus1.out_addr, 0);
    check("wrap_inst1", bus1.out_inst, 32'h0020_0093);
    push1(32'd3);
    @(negedge clk);
    check("wrap_full", bus1.in_ready, 0);
    rst1 = 1'b1;
    @(negedge clk);
    check("flush_valid", bus1.out_valid, 0);
    check("flush_in_ready", bus1.in_ready, 1);
    rst1 = 1'b0;
    push1(32'd5);
    @(negedge clk);
    check("post_rst_valid", bus1.out_valid, 1);
    check("post_rst_addr", bus1.out_addr, 12);
    check("post_rst_inst", bus1.out_inst, 32'h0050_0093);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
